// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and its decoder:
// FSM states, decoder instruction codes and instruction class codes.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_SYSTEM
  } class_e;

  // Decoder instruction codes; 63 is reserved for "not recognised".
  localparam logic [5:0] ID_ADD     = 6'd0;
  localparam logic [5:0] ID_ADDI    = 6'd1;
  localparam logic [5:0] ID_SUB     = 6'd2;
  localparam logic [5:0] ID_LUI     = 6'd3;
  localparam logic [5:0] ID_LB      = 6'd8;
  localparam logic [5:0] ID_LW      = 6'd9;
  localparam logic [5:0] ID_SB      = 6'd12;
  localparam logic [5:0] ID_SW      = 6'd13;
  localparam logic [5:0] ID_BEQ     = 6'd16;
  localparam logic [5:0] ID_BNE     = 6'd17;
  localparam logic [5:0] ID_BLT     = 6'd18;
  localparam logic [5:0] ID_JAL     = 6'd24;
  localparam logic [5:0] ID_JALR    = 6'd25;
  localparam logic [5:0] ID_ECALL   = 6'd30;
  localparam logic [5:0] ID_EBREAK  = 6'd31;
  localparam logic [5:0] ILLEGAL_ID = 6'd63;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/instr_classify.sv
// Combinational mapping from decoder instruction code to instruction class.
// Unknown codes (including the illegal code) fall into the ALU class; the
// sequencer detects the illegal code separately.
module instr_classify
  import instr_sequencer_pkg::*;
(
  input  logic [5:0] i_instr_id,
  output class_e     o_class
);

  // Classify the instruction code.
  // NOTE: the output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_class = CLS_ALU;
    case (i_instr_id)
      ID_ADD, ID_ADDI, ID_SUB, ID_LUI: o_class = CLS_ALU;
      ID_LB, ID_LW:                    o_class = CLS_LOAD;
      ID_SB, ID_SW:                    o_class = CLS_STORE;
      ID_BEQ, ID_BNE, ID_BLT:          o_class = CLS_BRANCH;
      ID_JAL, ID_JALR:                 o_class = CLS_JUMP;
      ID_ECALL, ID_EBREAK:             o_class = CLS_SYSTEM;
      default:                         o_class = CLS_ALU;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Handshake strobes that must react in the same cycle as an input (fetch
// request drop, decoder latch, register write) are decoded from the
// registered state; everything else is registered.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEC_LAT  = 2
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_latch,
  input  logic [5:0]  instr_id,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  input  logic [31:0] target_pc,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [3:0] DEC_LAT_W = 4'(DEC_LAT);

  state_e      r_state;
  class_e      r_class;
  logic [31:0] r_pc;
  logic [31:0] r_instret;
  logic [3:0]  r_cnt;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic        r_halted;
  logic        r_illegal;

  class_e      w_class;
  logic        w_take_target;
  logic        w_misaligned;

  instr_classify u_classify (
    .i_instr_id (instr_id),
    .o_class    (w_class)
  );

  // A jump always redirects; a branch redirects only when the ALU says so.
  assign w_take_target = (r_class == CLS_JUMP) ||
                         ((r_class == CLS_BRANCH) && branch_taken);
  assign w_misaligned  = (r_state == ST_WB) && w_take_target &&
                         is_misaligned(target_pc[1:0]);

  // Request drops in the ack cycle so it never overlaps the latch strobe.
  assign imem_req    = (r_state == ST_FETCH) && !imem_ack;
  assign instr_latch = (r_state == ST_FETCH) && imem_ack;
  assign rf_we       = (r_state == ST_WB) && !w_misaligned &&
                       (r_class != CLS_STORE) && (r_class != CLS_BRANCH);

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instret   = r_instret;
  assign dmem_req  = r_dmem_req;
  assign dmem_we   = r_dmem_we;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

  // Sequencer FSM with its registered outputs, PC and retire counter.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_class    <= CLS_ALU;
      r_pc       <= RESET_PC;
      r_instret  <= '0;
      r_cnt      <= '0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            r_state <= ST_DECODE;
            r_cnt   <= DEC_LAT_W;
          end
        end
        ST_DECODE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_class <= w_class;
          if (instr_id == ILLEGAL_ID) begin
            r_state   <= ST_HALT;
            r_halted  <= 1'b1;
            r_illegal <= 1'b1;
          end else if (w_class == CLS_SYSTEM) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if ((w_class == CLS_LOAD) || (w_class == CLS_STORE)) begin
            r_state    <= ST_MEM;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= (w_class == CLS_STORE);
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            r_state    <= ST_WB;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
          end
        end
        ST_WB: begin
          if (w_misaligned) begin
            r_state   <= ST_HALT;
            r_halted  <= 1'b1;
            r_illegal <= 1'b1;
          end else begin
            r_pc      <= w_take_target ? target_pc : r_pc + PC_STEP;
            r_instret <= r_instret + 32'd1;
            r_state   <= ST_FETCH;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
